sgdmac_rd_arbiter: RTL and testbench



---
 rtl/sgdmac_pkg.sv | 23 ++
 rtl/sgdmac_rd_arbiter_rr_arb2.sv | 36 +++
 rtl/sgdmac_rd_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_sgdmac_rd_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sgdmac_pkg.sv
// ---------------------------------------------------------------------------
// sgdmac_pkg
//   Shared types and constants for the SGDMAC read-side arbiter.
//   - arb_state_t : arbiter FSM states (idle / address phase / data phase)
//   - DEF_*_W     : default AXI widths used as parameter defaults
//   - ARSIZE_4B, ARBURST_INCR : AXI encodings used by the requesters
// ---------------------------------------------------------------------------
package sgdmac_pkg;

  localparam int DEF_ID_W   = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [2:0] ARSIZE_4B    = 3'b010;
  localparam logic [1:0] ARBURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sgdmac_rd_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-input grant logic, purely combinational. Output is one-hot.
//   Ports:
//     i_req[1:0]    request vector (bit0 = M0, bit1 = M1)
//     i_last_grant  index of the requester served last
//     o_grant[1:0]  one-hot grant, 0 when nobody requests
//   Build option:
//     SGDMAC_RD_ARB_FIXED_PRIO_EN defined   -> M0 always wins a tie
//     SGDMAC_RD_ARB_FIXED_PRIO_EN undefined -> round-robin on last_grant
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

`ifdef SGDMAC_RD_ARB_FIXED_PRIO_EN
  // Descriptor fetch must never starve behind long data streams.
  logic w_unused_lg;
  assign w_unused_lg = i_last_grant;

  always_comb begin
    o_grant = 2'b00;
    if (i_req[0])      o_grant = 2'b01;
    else if (i_req[1]) o_grant = 2'b10;
  end
`else
  // On a tie, the requester that was not served last wins.
  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) o_grant = i_last_grant ? 2'b01 : 2'b10;
  end
`endif

endmodule

// File: rtl/sgdmac_rd_arbiter.sv
// ---------------------------------------------------------------------------
// sgdmac_rd_arbiter
//   Shares one AXI read port between the descriptor fetcher (M0) and the
//   read data engine (M1). One outstanding burst at a time: the grant taken
//   in S_IDLE is held through the AR handshake and the whole R burst, whose
//   beats are routed back to the owner. Burst length is checked against the
//   rlast position.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     m0_ar*/m1_ar*        requester AR channels (in), m*_arready (out)
//     m0_r*/m1_r*          requester R channels (out), m*_rready (in)
//     s_ar*                AR channel to interconnect
//     s_r*                 R channel from interconnect
//     owner_o              grant index (0=M0, 1=M1), valid while busy_o
//     busy_o               high in S_AR or S_R
//     err_o                sticky: rlast/beat-count mismatch or stray beat
//   Build option: SGDMAC_RD_ARB_FIXED_PRIO_EN (see rr_arb2).
// ---------------------------------------------------------------------------
module sgdmac_rd_arbiter
  import sgdmac_pkg::*;
#(
  parameter int ID_W   = DEF_ID_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  // M0: descriptor fetcher
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [3:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [ID_W-1:0]   m0_rid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // M1: read data engine
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [3:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [ID_W-1:0]   m1_rid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // Interconnect side
  output logic [ID_W-1:0]   s_arid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [3:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [ID_W-1:0]   s_rid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              s_rready,
  // Status
  output logic              owner_o,
  output logic              busy_o,
  output logic              err_o
);

  arb_state_t r_state;
  logic       r_owner;
  logic       r_last_grant;
  logic [3:0] r_beat_cnt;
  logic [3:0] r_len_q;
  logic       r_err;

  logic [1:0] w_req;
  logic [1:0] w_grant;
  logic       w_in_ar;
  logic       w_in_r;
  logic       w_busy;
  logic       w_sel0;
  logic       w_sel1;
  logic       w_own_arvalid;
  logic       w_own_rready;
  logic [3:0] w_own_arlen;
  logic       w_ar_hs;
  logic       w_beat;

  assign w_req = {m1_arvalid, m0_arvalid};

  rr_arb2 u_rr_arb2 (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_in_ar = (r_state == S_AR);
  assign w_in_r  = (r_state == S_R);
  assign w_busy  = w_in_ar | w_in_r;

  // Per-requester selects; both are low when no grant is held.
  assign w_sel0 = w_busy & ~r_owner;
  assign w_sel1 = w_busy &  r_owner;

  assign w_own_arvalid = r_owner ? m1_arvalid : m0_arvalid;
  assign w_own_rready  = r_owner ? m1_rready  : m0_rready;
  assign w_own_arlen   = r_owner ? m1_arlen   : m0_arlen;

  // AR channel: payload follows the owner for the whole grant, zero otherwise.
  always_comb begin
    s_arid    = '0;
    s_araddr  = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    if (w_sel0) begin
      s_arid    = m0_arid;
      s_araddr  = m0_araddr;
      s_arlen   = m0_arlen;
      s_arsize  = m0_arsize;
      s_arburst = m0_arburst;
    end else if (w_sel1) begin
      s_arid    = m1_arid;
      s_araddr  = m1_araddr;
      s_arlen   = m1_arlen;
      s_arsize  = m1_arsize;
      s_arburst = m1_arburst;
    end
  end

  assign s_arvalid  = w_in_ar & w_own_arvalid;
  assign m0_arready = w_in_ar & ~r_owner & s_arready;
  assign m1_arready = w_in_ar &  r_owner & s_arready;
  assign w_ar_hs    = s_arvalid & s_arready;

  // R channel: stray beats outside S_R are never accepted.
  assign s_rready = w_in_r & w_own_rready;
  assign w_beat   = s_rvalid & s_rready;

  assign m0_rvalid = w_in_r & ~r_owner & s_rvalid;
  assign m1_rvalid = w_in_r &  r_owner & s_rvalid;
  assign m0_rid    = (w_in_r & ~r_owner) ? s_rid   : '0;
  assign m0_rdata  = (w_in_r & ~r_owner) ? s_rdata : '0;
  assign m0_rresp  = (w_in_r & ~r_owner) ? s_rresp : '0;
  assign m0_rlast  = (w_in_r & ~r_owner) ? s_rlast : 1'b0;
  assign m1_rid    = (w_in_r &  r_owner) ? s_rid   : '0;
  assign m1_rdata  = (w_in_r &  r_owner) ? s_rdata : '0;
  assign m1_rresp  = (w_in_r &  r_owner) ? s_rresp : '0;
  assign m1_rlast  = (w_in_r &  r_owner) ? s_rlast : 1'b0;

  assign owner_o = r_owner;
  assign busy_o  = w_busy;
  assign err_o   = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_beat_cnt   <= 4'd0;
      r_len_q      <= 4'd0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s_rvalid) r_err <= 1'b1;
          if (|w_req) begin
            r_owner <= w_grant[1];
            r_state <= S_AR;
          end
        end
        S_AR: begin
          if (s_rvalid) r_err <= 1'b1;
          if (w_ar_hs) begin
            r_len_q    <= w_own_arlen;
            r_beat_cnt <= 4'd0;
            r_state    <= S_R;
          end
        end
        S_R: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 4'd1;
            if (s_rlast) begin
              // Last beat must sit at index arlen.
              if (r_beat_cnt != r_len_q) r_err <= 1'b1;
              r_last_grant <= r_owner;
              r_state      <= S_IDLE;
            end else if (r_beat_cnt == r_len_q) begin
              // Burst overran arlen; keep draining until rlast.
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sgdmac_rd_arbiter.sv
module tb_sgdmac_rd_arbiter;
  import sgdmac_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0]  m0_arid = '0, m1_arid = '0;
  logic [31:0] m0_araddr = '0, m1_araddr = '0;
  logic [3:0]  m0_arlen = '0, m1_arlen = '0;
  logic [2:0]  m0_arsize = ARSIZE_4B, m1_arsize = ARSIZE_4B;
  logic [1:0]  m0_arburst = ARBURST_INCR, m1_arburst = ARBURST_INCR;
  logic        m0_arvalid = 1'b0, m1_arvalid = 1'b0;
  logic        m0_arready, m1_arready;
  logic [3:0]  m0_rid, m1_rid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid;
  logic        m0_rready = 1'b1, m1_rready = 1'b1;
  logic [3:0]  s_arid;
  logic [31:0] s_araddr;
  logic [3:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_arvalid;
  logic        s_arready = 1'b0;
  logic [3:0]  s_rid = '0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = '0;
  logic        s_rlast = 1'b0, s_rvalid = 1'b0;
  logic        s_rready;
  logic        owner_o, busy_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;

  // {owner, id, addr, len, size, burst}
  logic [45:0] exp_ar[$];
  // {rlast, rresp, rid, rdata}
  logic [38:0] exp_r0[$];
  logic [38:0] exp_r1[$];

  sgdmac_rd_arbiter #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid),
    .m0_arready(m0_arready), .m0_rid(m0_rid), .m0_rdata(m0_rdata),
    .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid),
    .m0_rready(m0_rready),
    .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid),
    .m1_arready(m1_arready), .m1_rid(m1_rid), .m1_rdata(m1_rdata),
    .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid),
    .m1_rready(m1_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready),
    .owner_o(owner_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a handshake is visible.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_arvalid && s_arready) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
        else chk("ar_payload", {owner_o, s_arid, s_araddr, s_arlen, s_arsize, s_arburst},
                 exp_ar.pop_front());
      end
      if (m0_rvalid && m0_rready) begin
        if (exp_r0.size() == 0) chk("m0_r_unexpected", 1, 0);
        else chk("m0_r_beat", {m0_rlast, m0_rresp, m0_rid, m0_rdata}, exp_r0.pop_front());
      end
      if (m1_rvalid && m1_rready) begin
        if (exp_r1.size() == 0) chk("m1_r_unexpected", 1, 0);
        else chk("m1_r_beat", {m1_rlast, m1_rresp, m1_rid, m1_rdata}, exp_r1.pop_front());
      end
    end
  end

  task automatic ar_issue(input int m, input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len);
    if (m == 0) begin
      m0_arid = id; m0_araddr = addr; m0_arlen = len; m0_arvalid = 1'b1;
    end else begin
      m1_arid = id; m1_araddr = addr; m1_arlen = len; m1_arvalid = 1'b1;
    end
  endtask

  // Expect requester m to win next; call from idle at posedge+#1.
  task automatic ar_wait(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input int dly);
    int c = 0;
    bit hs = 0;
    exp_ar.push_back({m[0], id, addr, len, 3'b010, 2'b01});
    s_arready = 1'b0;
    @(negedge clk);
    chk("ar_lat0_idle", s_arvalid, 0);
    while (!hs && c < 50) begin
      @(posedge clk); #1;
      s_arready = (c >= dly);
      @(negedge clk);
      if (c == 0) chk("ar_lat1_valid", s_arvalid, 1);
      chk("ar_nonowner_rdy", (m == 0) ? m1_arready : m0_arready, 0);
      chk("ar_owner", owner_o, m[0]);
      hs = s_arvalid && s_arready;
      c++;
    end
    if (!hs) chk("ar_timeout", 0, 1);
    @(posedge clk); #1;
    if (m == 0) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
    s_arready = 1'b0;
  endtask

  // Slave returns n beats to requester m; rlast on beat last_idx.
  task automatic r_burst(input int m, input int n, input int last_idx, input logic [3:0] id,
                         input logic [31:0] base, input bit tog);
    for (int i = 0; i < n; i++) begin
      int c = 0;
      bit hs = 0;
      s_rvalid = 1'b1;
      s_rdata  = base + i;
      s_rlast  = (i == last_idx);
      s_rid    = id;
      s_rresp  = 2'(i);
      if (m == 0) exp_r0.push_back({s_rlast, s_rresp, id, s_rdata});
      else        exp_r1.push_back({s_rlast, s_rresp, id, s_rdata});
      while (!hs && c < 40) begin
        if (tog) m1_rready = ~m1_rready;
        @(negedge clk);
        hs = s_rready;
        chk("r_nonowner_vld", (m == 0) ? m1_rvalid : m0_rvalid, 0);
        chk("r_nonowner_ardy", (m == 0) ? m1_arready : m0_arready, 0);
        @(posedge clk); #1;
        c++;
      end
      if (!hs) chk("r_timeout", 0, 1);
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    m1_rready = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_owner", owner_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_valids", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}, 0);
    chk("rst_payload", s_araddr, 0);

    // Tie after reset, then a second tie.
    @(posedge clk); #1;
    ar_issue(0, 4'h1, 32'h2000, 4'd0);
    ar_issue(1, 4'h2, 32'h3000, 4'd0);
    ar_wait(0, 4'h1, 32'h2000, 4'd0, 0);
    r_burst(0, 1, 0, 4'h1, 32'hA000_0000, 0);
    ar_issue(0, 4'h3, 32'h2100, 4'd0);
`ifdef SGDMAC_RD_ARB_FIXED_PRIO_EN
    ar_wait(0, 4'h3, 32'h2100, 4'd0, 0);
    r_burst(0, 1, 0, 4'h3, 32'hA100_0000, 0);
    ar_wait(1, 4'h2, 32'h3000, 4'd0, 0);
    r_burst(1, 1, 0, 4'h2, 32'hB000_0000, 0);
`else
    ar_wait(1, 4'h2, 32'h3000, 4'd0, 0);
    r_burst(1, 1, 0, 4'h2, 32'hB000_0000, 0);
    ar_wait(0, 4'h3, 32'h2100, 4'd0, 0);
    r_burst(0, 1, 0, 4'h3, 32'hA100_0000, 0);
`endif

    // M0 only, 4-beat burst.
    ar_issue(0, 4'h5, 32'h1000, 4'd3);
    ar_wait(0, 4'h5, 32'h1000, 4'd3, 0);
    chk("m0_busy_in_r", busy_o, 1);
    r_burst(0, 4, 3, 4'h5, 32'h1111_0000, 0);
    @(negedge clk);
    chk("m0_done_idle", busy_o, 0);
    chk("m0_done_err", err_o, 0);
    @(posedge clk); #1;

    // M1 16-beat burst, late arready, toggling rready; M0 waits.
    ar_issue(1, 4'h9, 32'h8000, 4'd15);
    ar_wait(1, 4'h9, 32'h8000, 4'd15, 5);
    ar_issue(0, 4'h6, 32'h1200, 4'd0);
    r_burst(1, 16, 15, 4'h9, 32'h2222_0000, 1);
    ar_wait(0, 4'h6, 32'h1200, 4'd0, 0);
    r_burst(0, 1, 0, 4'h6, 32'h3333_0000, 0);
    @(negedge clk);
    chk("m1_long_err", err_o, 0);
    @(posedge clk); #1;

    // Early rlast: arlen=7 but rlast on beat 3.
    ar_issue(0, 4'h7, 32'h4000, 4'd7);
    ar_wait(0, 4'h7, 32'h4000, 4'd7, 0);
    r_burst(0, 4, 3, 4'h7, 32'h4444_0000, 0);
    @(negedge clk);
    chk("early_rlast_err", err_o, 1);
    chk("early_rlast_idle", busy_o, 0);
    @(posedge clk); #1;
    ar_issue(1, 4'hA, 32'h5000, 4'd1);
    ar_wait(1, 4'hA, 32'h5000, 4'd1, 0);
    r_burst(1, 2, 1, 4'hA, 32'h5555_0000, 0);
    @(negedge clk);
    chk("err_sticky", err_o, 1);
    @(posedge clk); #1;

    // Reset during beat 2 of a burst.
    ar_issue(0, 4'hB, 32'h6000, 4'd3);
    ar_wait(0, 4'hB, 32'h6000, 4'd3, 0);
    r_burst(0, 2, 99, 4'hB, 32'h6666_0000, 0);
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; m0_rready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("prerst_in_r", busy_o, 1);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valids", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_payload", m0_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0; s_rvalid = 1'b0; m0_rready = 1'b1;

    // Stray beat while idle.
    @(posedge clk); #1;
    s_rvalid = 1'b1;
    @(negedge clk);
    chk("stray_rready", s_rready, 0);
    @(posedge clk); #1;
    s_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_err", err_o, 1);

    chk("ar_queue_empty", exp_ar.size(), 0);
    chk("r0_queue_empty", exp_r0.size(), 0);
    chk("r1_queue_empty", exp_r1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
